// File: rtl/incubator_zone_ctrl.sv
// Multi-zone incubator controller: per-zone heat/cool hysteresis FSM,
// ramped cooler rotation speed and a persistence-filtered latched alarm.
module incubator_zone_ctrl #(
    parameter int N_ZONES      = 2,
    parameter int TW           = 8,
    parameter int CRS_W        = 4,
    parameter int HEAT_ON      = 15,
    parameter int HEAT_OFF     = 25,
    parameter int COOL_OFF     = 30,
    parameter int COOL_ON      = 35,
    parameter int BASE_SPEED   = 4,
    parameter int STEP_SHIFT   = 2,
    parameter int ALARM_HIGH   = 50,
    parameter int ALARM_LOW    = -5,
    parameter int ALARM_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_ZONES*TW-1:0]    temp,
    input  logic [N_ZONES-1:0]       alarm_clr,
    output logic [N_ZONES-1:0]       heater,
    output logic [N_ZONES-1:0]       cooler,
    output logic [N_ZONES*CRS_W-1:0] crs,
    output logic [N_ZONES-1:0]       alarm,
    output logic                     any_alarm
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAT = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    localparam int CW      = $clog2(ALARM_CYCLES + 1);
    localparam int CRS_MAX = (1 << CRS_W) - 1;

    localparam logic signed [TW-1:0] HEAT_ON_T  = TW'(HEAT_ON);
    localparam logic signed [TW-1:0] HEAT_OFF_T = TW'(HEAT_OFF);
    localparam logic signed [TW-1:0] COOL_OFF_T = TW'(COOL_OFF);
    localparam logic signed [TW-1:0] COOL_ON_T  = TW'(COOL_ON);
    localparam logic signed [TW-1:0] AL_HIGH_T  = TW'(ALARM_HIGH);
    localparam logic signed [TW-1:0] AL_LOW_T   = TW'(ALARM_LOW);
    localparam logic signed [TW:0]   COOL_ON_X  = (TW+1)'(COOL_ON);
    localparam logic [TW+1:0]        BASE_X     = (TW+2)'(BASE_SPEED);
    localparam logic [TW+1:0]        CRS_MAX_X  = (TW+2)'(CRS_MAX);
    localparam logic [CRS_W-1:0]     CRS_MAX_V  = CRS_W'(CRS_MAX);
    localparam logic [CW-1:0]        ALARM_N    = CW'(ALARM_CYCLES);

    function automatic state_t state_next(input state_t cur, input logic signed [TW-1:0] t);
        state_t nxt;
        nxt = cur;
        unique case (cur)
            ST_IDLE: begin
                if (t < HEAT_ON_T)
                    nxt = ST_HEAT;
                else if (t > COOL_ON_T)
                    nxt = ST_COOL;
            end
            ST_HEAT: if (t >= HEAT_OFF_T) nxt = ST_IDLE;
            ST_COOL: if (t <= COOL_OFF_T) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    // Excess above COOL_ON is taken at TW+1 bits so extreme inputs cannot wrap.
    function automatic logic [CRS_W-1:0] crs_target(input logic cool, input logic signed [TW-1:0] t);
        logic signed [TW:0] diff;
        logic [TW:0]        steps;
        logic [TW+1:0]      sum;
        diff  = $signed({t[TW-1], t}) - COOL_ON_X;
        steps = diff[TW] ? '0 : ($unsigned(diff) >> STEP_SHIFT);
        sum   = {1'b0, steps} + BASE_X;
        if (!cool)
            return '0;
        else if (sum > CRS_MAX_X)
            return CRS_MAX_V;
        else
            return sum[CRS_W-1:0];
    endfunction

    function automatic logic [CRS_W-1:0] crs_step(input logic [CRS_W-1:0] cur, input logic [CRS_W-1:0] tgt);
        if (cur < tgt)
            return cur + 1'b1;
        else if (cur > tgt)
            return cur - 1'b1;
        else
            return cur;
    endfunction

    function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] cur);
        if (cur == ALARM_N)
            return cur;
        else
            return cur + 1'b1;
    endfunction

    function automatic logic out_of_range(input logic signed [TW-1:0] t);
        return (t > AL_HIGH_T) || (t < AL_LOW_T);
    endfunction

    logic signed [TW-1:0] w_temp      [N_ZONES];
    state_t               r_state     [N_ZONES];
    state_t               w_state_nxt [N_ZONES];
    logic [CRS_W-1:0]     r_crs       [N_ZONES];
    logic [CRS_W-1:0]     w_crs_nxt   [N_ZONES];
    logic [CW-1:0]        r_cnt       [N_ZONES];
    logic [CW-1:0]        w_cnt_nxt   [N_ZONES];
    logic [N_ZONES-1:0]   r_alarm;
    logic [N_ZONES-1:0]   w_alarm_nxt;

    always_comb begin
        for (int z = 0; z < N_ZONES; z++) begin
            w_temp[z] = temp[z*TW +: TW];
        end
    end

    always_comb begin
        w_alarm_nxt = r_alarm;
        for (int z = 0; z < N_ZONES; z++) begin
            w_state_nxt[z] = state_next(r_state[z], w_temp[z]);
            w_crs_nxt[z]   = crs_step(r_crs[z],
                                      crs_target(w_state_nxt[z] == ST_COOL, w_temp[z]));
            // Clear wins over a set landing on the same edge.
            if (alarm_clr[z]) begin
                w_cnt_nxt[z]   = '0;
                w_alarm_nxt[z] = 1'b0;
            end else if (out_of_range(w_temp[z])) begin
                w_cnt_nxt[z]   = cnt_sat_inc(r_cnt[z]);
                w_alarm_nxt[z] = r_alarm[z] | (cnt_sat_inc(r_cnt[z]) == ALARM_N);
            end else begin
                w_cnt_nxt[z]   = '0;
                w_alarm_nxt[z] = r_alarm[z];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int z = 0; z < N_ZONES; z++) begin
                r_state[z] <= ST_IDLE;
                r_crs[z]   <= '0;
                r_cnt[z]   <= '0;
            end
            r_alarm <= '0;
        end else begin
            for (int z = 0; z < N_ZONES; z++) begin
                r_state[z] <= w_state_nxt[z];
                r_crs[z]   <= w_crs_nxt[z];
                r_cnt[z]   <= w_cnt_nxt[z];
            end
            r_alarm <= w_alarm_nxt;
        end
    end

    // The alarm only gates the heater output; the FSM keeps tracking temperature.
    always_comb begin
        heater = '0;
        cooler = '0;
        crs    = '0;
        for (int z = 0; z < N_ZONES; z++) begin
            heater[z]               = (r_state[z] == ST_HEAT) & ~r_alarm[z];
            cooler[z]               = (r_state[z] == ST_COOL);
            crs[z*CRS_W +: CRS_W]   = r_crs[z];
        end
    end

    assign alarm     = r_alarm;
    assign any_alarm = |r_alarm;

endmodule
